tos_stop_capture: RTL
=====================

// Module: tos_stop_capture
// PURPOSE
//  Receive end of the timing FPGA's top-of-second (TOS) and TDC-stop strobes.
//  Keeps a clk_tf cycle counter that restarts at each TOS and records the coarse
//  TOS->stop interval, which complements the TDC fine measurement. Validates the
//  TOS period, counts seconds, and hands one record per second to the uC/DDC side
//  over a valid/ready interface.
// PARAMETERS
//  ClocksPerSecond  19200000  expected clk_tf cycles between TOS edges
//  CountWidth       25        coarse counter width; must satisfy 2^CountWidth > ClocksPerSecond
//  LockCount        3         consecutive good periods before tos_locked asserts
// PORTS
//  clk_tf         in   1    timing clock, 19.2 MHz
//  tf_reset_l     in   1    asynchronous active-low reset
//  tos_mark_next  in   1    1-cycle pulse; next clk_tf rising edge is TOS
//  tdc_stop_next  in   1    level; external flop drives TDC stop from this on the next edge
//  rec_ready      in   1    consumer accepts record
//  rec_valid      out  1    record available
//  rec_seconds    out  32   index of the second the record closes
//  rec_coarse     out  CountWidth  cycles from TOS edge to stop edge
//  rec_flags      out  4    {overrun, multi_stop, no_stop, period_err}
//  tos_locked     out  1    TOS period stable
// BEHAVIOUR
//  Reset (async assert, sync release): rec_valid=0, rec_seconds=0, rec_coarse=0,
//   rec_flags=0, tos_locked=0, state=S_WAIT_TOS, all counters=0, sticky overrun=0.
//  Edge E_TOS is a clock edge at which tos_mark_next was sampled 1. At E_TOS:
//   cyc_cnt<=0. At every other edge: cyc_cnt<=cyc_cnt+1, saturating at all-ones.
//  Edge E_STOP is a clock edge at which tdc_stop_next is sampled 1 and the previous
//   sample was 0; the external stop flop rises at this same edge.
//   At E_STOP: captured coarse = value cyc_cnt takes at that edge (0 if it coincides with E_TOS).
//  FSM:
//   S_WAIT_TOS: ignore stops. On E_TOS -> S_OPEN. No record is produced.
//   S_OPEN: on E_STOP, latch coarse and go to S_HELD. On E_TOS, close the second with
//    no_stop=1 and coarse=all-ones, then stay in S_OPEN.
//   S_HELD: an additional E_STOP sets multi_stop; the first capture is kept.
//    On E_TOS, close the second and go to S_OPEN.
//  Closing a second at E_TOS:
//   - build the record {sec_cnt, coarse, flags}, then sec_cnt<=sec_cnt+1 (32-bit wrap).
//   - period_err=1 if the pre-edge cyc_cnt != ClocksPerSecond-1.
//  E_STOP and E_TOS on the same edge: close the old second first (no stop in it).
//   The stop then belongs to the new second with coarse=0, and the FSM goes to S_HELD.
//  Lock: good_cnt increments on each E_TOS that has no period_err, and clears on one with
//   period_err. tos_locked=1 while good_cnt>=LockCount; it drops on the same edge that
//   flags period_err. The first E_TOS (from S_WAIT_TOS) is not checked.
//  Output handshake:
//   - The record registers load on the edge after E_TOS, so latency is 1 cycle.
//   - A transfer happens when rec_valid&&rec_ready.
//   - Data and flags stay stable while rec_valid=1 and rec_ready=0.
//   - If rec_valid=1 and the record is not accepted when a new one is due, drop the new
//    record and set sticky overrun. The next loaded record carries overrun=1, and the
//    sticky bit clears on that load.
//   - The record is a single register; there is no FIFO.
//  Reset mid-operation: a pending record is discarded and rec_valid falls immediately (async).
// TESTING
//  (Sim params: ClocksPerSecond=100, CountWidth=8, LockCount=3, rec_ready=1 unless stated.)
//  1. TOS every 100 cycles, stop_next rises 37 cycles after each E_TOS -> rec_coarse=37,
//     flags=0, rec_seconds=0,1,2...; tos_locked=1 after the 4th TOS.
//  2. Omit the stop in one second -> that record has no_stop=1 and rec_coarse=255; the
//     next second is normal.
//  3. Second TOS arrives after 99 cycles -> period_err=1, tos_locked drops; it reasserts
//     after 3 good periods.
//  4. Stop rise on the same edge as E_TOS -> the closing record has no_stop=1; the next
//     record has coarse=0. Two stops (20, 60) -> coarse=20, multi_stop=1.
//  5. Hold rec_ready=0 across 2 TOS -> the first record stays stable and the second is
//     dropped. Raise ready -> the third record has overrun=1 and rec_seconds skips by 2.
//  6. Assert tf_reset_l=0 mid-second with rec_valid=1 -> all outputs reset at once; stops
//     are ignored until the first TOS, and no record comes from that TOS.

Source files
------------

// File: rtl/tos_stop_capture_if.sv
// Record handoff channel from the TOS/stop capture block to the uC/DDC consumer.
interface tos_stop_capture_if #(
  parameter int unsigned CountWidth = 25
);
  logic                  rec_valid;
  logic                  rec_ready;
  logic [31:0]           rec_seconds;
  logic [CountWidth-1:0] rec_coarse;
  logic [3:0]            rec_flags;

  modport master (
    output rec_valid,
    output rec_seconds,
    output rec_coarse,
    output rec_flags,
    input  rec_ready
  );

  modport slave (
    input  rec_valid,
    input  rec_seconds,
    input  rec_coarse,
    input  rec_flags,
    output rec_ready
  );
endinterface

// File: rtl/tos_stop_capture.sv
// Coarse TOS->stop interval capture with TOS period validation, second counting
// and a single-entry valid/ready record output.
module tos_stop_capture #(
  parameter int unsigned ClocksPerSecond = 19200000,
  parameter int unsigned CountWidth      = 25,
  parameter int unsigned LockCount       = 3
) (
  input  logic                       clk_tf,
  input  logic                       tf_reset_l,
  input  logic                       tos_mark_next,
  input  logic                       tdc_stop_next,
  tos_stop_capture_if.master         rec,
  output logic                       tos_locked
);

  localparam int unsigned GoodWidth = (LockCount < 1) ? 1 : $clog2(LockCount + 1);
  localparam logic [CountWidth-1:0] CntMax    = '1;
  localparam logic [CountWidth-1:0] PeriodEnd = CountWidth'(ClocksPerSecond - 1);
  localparam logic [GoodWidth-1:0]  GoodMax   = GoodWidth'(LockCount);

  typedef enum logic [1:0] {
    S_WAIT_TOS = 2'd0,
    S_OPEN     = 2'd1,
    S_HELD     = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [CountWidth-1:0] cyc_cnt_q, cyc_cnt_d;
  logic                  stop_prev_q, stop_prev_d;
  logic [CountWidth-1:0] cap_coarse_q, cap_coarse_d;
  logic                  multi_q, multi_d;
  logic [31:0]           sec_cnt_q, sec_cnt_d;
  logic [GoodWidth-1:0]  good_cnt_q, good_cnt_d;
  logic                  locked_q, locked_d;
  logic                  overrun_q, overrun_d;

  // Closed-second record waiting one cycle before it reaches the output register.
  logic                  pend_valid_q, pend_valid_d;
  logic [31:0]           pend_seconds_q, pend_seconds_d;
  logic [CountWidth-1:0] pend_coarse_q, pend_coarse_d;
  logic [2:0]            pend_flags_q, pend_flags_d;

  logic                  rec_valid_q, rec_valid_d;
  logic [31:0]           rec_seconds_q, rec_seconds_d;
  logic [CountWidth-1:0] rec_coarse_q, rec_coarse_d;
  logic [3:0]            rec_flags_q, rec_flags_d;

  logic tos_c;
  logic stop_c;
  logic period_err_c;

  // Capture, second-closing and lock tracking.
  always_comb begin
    tos_c          = tos_mark_next;
    stop_c         = tdc_stop_next && !stop_prev_q;
    period_err_c   = (cyc_cnt_q != PeriodEnd);

    state_d        = state_q;
    stop_prev_d    = tdc_stop_next;
    cap_coarse_d   = cap_coarse_q;
    multi_d        = multi_q;
    sec_cnt_d      = sec_cnt_q;
    good_cnt_d     = good_cnt_q;
    pend_valid_d   = 1'b0;
    pend_seconds_d = pend_seconds_q;
    pend_coarse_d  = pend_coarse_q;
    pend_flags_d   = pend_flags_q;

    if (tos_c) begin
      cyc_cnt_d = '0;
    end else if (cyc_cnt_q == CntMax) begin
      cyc_cnt_d = CntMax;
    end else begin
      cyc_cnt_d = cyc_cnt_q + CountWidth'(1);
    end

    case (state_q)
      S_WAIT_TOS: begin
        if (tos_c) begin
          state_d = S_OPEN;
        end
      end
      S_OPEN, S_HELD: begin
        if (tos_c) begin
          pend_valid_d   = 1'b1;
          pend_seconds_d = sec_cnt_q;
          pend_coarse_d  = (state_q == S_HELD) ? cap_coarse_q : CntMax;
          pend_flags_d   = {(state_q == S_HELD) && multi_q, state_q == S_OPEN, period_err_c};
          sec_cnt_d      = sec_cnt_q + 32'd1;
          if (period_err_c) begin
            good_cnt_d = '0;
          end else if (good_cnt_q != GoodMax) begin
            good_cnt_d = good_cnt_q + GoodWidth'(1);
          end
          // A stop on the TOS edge opens the new second with coarse 0.
          if (stop_c) begin
            cap_coarse_d = '0;
            multi_d      = 1'b0;
            state_d      = S_HELD;
          end else begin
            state_d      = S_OPEN;
          end
        end else if (stop_c) begin
          if (state_q == S_OPEN) begin
            cap_coarse_d = cyc_cnt_d;
            multi_d      = 1'b0;
            state_d      = S_HELD;
          end else begin
            multi_d      = 1'b1;
          end
        end
      end
      default: state_d = S_WAIT_TOS;
    endcase

    locked_d = (good_cnt_d >= GoodMax);
  end

  // Single-entry output register; a record arriving while one is stalled is dropped.
  always_comb begin
    rec_valid_d   = rec_valid_q && !rec.rec_ready;
    rec_seconds_d = rec_seconds_q;
    rec_coarse_d  = rec_coarse_q;
    rec_flags_d   = rec_flags_q;
    overrun_d     = overrun_q;

    if (pend_valid_q) begin
      if (rec_valid_q && !rec.rec_ready) begin
        overrun_d     = 1'b1;
      end else begin
        rec_valid_d   = 1'b1;
        rec_seconds_d = pend_seconds_q;
        rec_coarse_d  = pend_coarse_q;
        rec_flags_d   = {overrun_q, pend_flags_q};
        overrun_d     = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_tf or negedge tf_reset_l) begin
    if (!tf_reset_l) begin
      state_q        <= S_WAIT_TOS;
      cyc_cnt_q      <= '0;
      stop_prev_q    <= 1'b0;
      cap_coarse_q   <= '0;
      multi_q        <= 1'b0;
      sec_cnt_q      <= '0;
      good_cnt_q     <= '0;
      locked_q       <= 1'b0;
      overrun_q      <= 1'b0;
      pend_valid_q   <= 1'b0;
      pend_seconds_q <= '0;
      pend_coarse_q  <= '0;
      pend_flags_q   <= '0;
      rec_valid_q    <= 1'b0;
      rec_seconds_q  <= '0;
      rec_coarse_q   <= '0;
      rec_flags_q    <= '0;
    end else begin
      state_q        <= state_d;
      cyc_cnt_q      <= cyc_cnt_d;
      stop_prev_q    <= stop_prev_d;
      cap_coarse_q   <= cap_coarse_d;
      multi_q        <= multi_d;
      sec_cnt_q      <= sec_cnt_d;
      good_cnt_q     <= good_cnt_d;
      locked_q       <= locked_d;
      overrun_q      <= overrun_d;
      pend_valid_q   <= pend_valid_d;
      pend_seconds_q <= pend_seconds_d;
      pend_coarse_q  <= pend_coarse_d;
      pend_flags_q   <= pend_flags_d;
      rec_valid_q    <= rec_valid_d;
      rec_seconds_q  <= rec_seconds_d;
      rec_coarse_q   <= rec_coarse_d;
      rec_flags_q    <= rec_flags_d;
    end
  end

  assign rec.rec_valid   = rec_valid_q;
  assign rec.rec_seconds = rec_seconds_q;
  assign rec.rec_coarse  = rec_coarse_q;
  assign rec.rec_flags   = rec_flags_q;
  assign tos_locked      = locked_q;

endmodule
